// File: rtl/md_pkg.sv
// Shared encodings and default timing constants for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide unit.
interface md_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hilo_sel;
    logic        busy;
    logic [31:0] md_out;

    modport master (output start, md_op, A, B, hilo_sel, input busy, md_out);
    modport slave  (input start, md_op, A, B, hilo_sel, output busy, md_out);
endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing {hi, lo} for MULT/MULTU/DIV/DIVU.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic        signed_op;
    logic        is_div;
    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        signed_op = (op == MD_MULT) || (op == MD_DIV);
        is_div    = (op == MD_DIV)  || (op == MD_DIVU);

        // Low 64 bits of the extended product equal the true signed/unsigned product.
        a_ext = signed_op ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext = signed_op ? {{32{b[31]}}, b} : {32'd0, b};
        prod  = a_ext * b_ext;

        // Sign-magnitude division: 0x80000000 / -1 falls out as 0x80000000 rem 0.
        a_neg  = signed_op & a[31];
        b_neg  = signed_op & b[31];
        a_mag  = a_neg ? (32'd0 - a) : a;
        b_mag  = b_neg ? (32'd0 - b) : b;
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem    = a_neg ? (32'd0 - r_mag) : r_mag;

        hi       = is_div ? rem  : prod[63:32];
        lo       = is_div ? quot : prod[31:0];
        div_zero = is_div && (b == 32'd0);
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle MULT/DIV unit with private HI/LO, busy flag for the hazard unit and HI/LO read mux.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] pend_hi_reg, pend_hi_next;
    logic [31:0] pend_lo_reg, pend_lo_next;
    logic        pend_we_reg, pend_we_next;

    logic [31:0] arith_hi;
    logic [31:0] arith_lo;
    logic        arith_dz;

    md_arith u_arith (
        .op       (bus.md_op),
        .a        (bus.A),
        .b        (bus.B),
        .hi       (arith_hi),
        .lo       (arith_lo),
        .div_zero (arith_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            pend_we_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_we_reg <= pend_we_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_we_next = pend_we_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.md_op)
                        MD_MULT, MD_MULTU: begin
                            pend_hi_next = arith_hi;
                            pend_lo_next = arith_lo;
                            pend_we_next = 1'b1;
                            cnt_next     = CW'(MULT_CYCLES);
                            state_next   = ST_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            // A zero divisor still burns the full period but leaves HI/LO intact.
                            pend_hi_next = arith_hi;
                            pend_lo_next = arith_lo;
                            pend_we_next = !arith_dz;
                            cnt_next     = CW'(DIV_CYCLES);
                            state_next   = ST_BUSY;
                        end
                        MD_MTHI: hi_next = bus.A;
                        MD_MTLO: lo_next = bus.A;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == CW'(1)) begin
                    if (pend_we_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy   = (state_reg == ST_BUSY);
    assign bus.md_out = bus.hilo_sel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic reference model.
module tb_md_unit;
    import md_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic rst_n;
    md_if bus ();

    md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO.
    function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
            3'd1: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            3'd2: if (b != 0) begin sq = sa / sb; sr = sa % sb; exp_lo = sq[31:0]; exp_hi = sr[31:0]; end
            3'd3: if (b != 0) begin uq = ua / ub; ur = ua % ub; exp_lo = uq[31:0]; exp_hi = ur[31:0]; end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endfunction

    function automatic int busy_len(input logic [2:0] op);
        if (op <= 3'd1) return MULT_N;
        if (op <= 3'd3) return DIV_N;
        return 0;
    endfunction

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        bus.hilo_sel = 1'b1;
        #1 h = bus.md_out;
        bus.hilo_sel = 1'b0;
        #1 l = bus.md_out;
    endtask

    // Called shortly after a negedge; returns shortly after a later negedge, ready to chain.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        int cyc;
        logic [31:0] h, l;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        model_op(op, a, b);
        cyc = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && cyc < 60) begin
            cyc++;
            if (poke && cyc == 3) begin
                bus.start = 1'b1;
                bus.md_op = MD_MTLO;
                bus.A     = 32'h0000DEAD;
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, ".busy_cycles"}, 32'(cyc), 32'(busy_len(op)));
        read_hilo(h, l);
        check({tag, ".hi"}, h, exp_hi);
        check({tag, ".lo"}, l, exp_lo);
        $display("[TB] %s op=%0d A=%h B=%h busy=%0d HI=%h LO=%h", tag, op, a, b, cyc, h, l);
    endtask

    initial begin
        logic [31:0] h, l;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.md_op    = 3'd0;
        bus.A        = 32'd0;
        bus.B        = 32'd0;
        bus.hilo_sel = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset.busy", 32'(bus.busy), 32'd0);
        read_hilo(h, l);
        check("reset.hi", h, 32'd0);
        check("reset.lo", l, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        run_op("mult",  MD_MULT,  32'hFFFFFFFE, 32'd3, 1'b0);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
        run_op("div",   MD_DIV,   32'hFFFFFFF9, 32'd2, 1'b1);
        run_op("divu",  MD_DIVU,  32'd7,        32'd2, 1'b0);
        run_op("mthi",  MD_MTHI,  32'h12345678, 32'd0, 1'b0);
        run_op("pre_hi", MD_MTHI, 32'h000000AA, 32'd0, 1'b0);
        run_op("pre_lo", MD_MTLO, 32'h000000BB, 32'd0, 1'b0);
        run_op("div0",  MD_DIV,   32'h00001234, 32'd0, 1'b0);
        run_op("divu0", MD_DIVU,  32'hFFFFFFFF, 32'd0, 1'b0);
        run_op("divovf", MD_DIV,  32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op("rsvd6", 3'd6,     32'h55555555, 32'd1, 1'b0);
        run_op("rsvd7", 3'd7,     32'h66666666, 32'd1, 1'b0);

        // Asynchronous reset in the third busy cycle of a MULT.
        bus.start = 1'b1;
        bus.md_op = MD_MULT;
        bus.A     = 32'd1000;
        bus.B     = 32'd1000;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid.busy", 32'(bus.busy), 32'd0);
        read_hilo(h, l);
        check("rst_mid.hi", h, 32'd0);
        check("rst_mid.lo", l, 32'd0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        run_op("post_rst_multu", MD_MULTU, 32'd2, 32'd3, 1'b0);
        run_op("b2b_mult",       MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000000F;
            run_op($sformatf("rand%0d", i), rop, ra, rb, ($urandom_range(0, 3) == 0) && (rop <= 3'd3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
